// File: rtl/cnn_pkg.sv
// Shared CNN datapath definitions: pixel width, window packing order and
// counter-width helpers used by the window generator, mult_adder and kernel loader.
package cnn_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int IMG_W_DEF  = 8;
  localparam int IMG_H_DEF  = 8;

  localparam int COL_W_DEF = (IMG_W_DEF > 1) ? $clog2(IMG_W_DEF) : 1;
  localparam int ROW_W_DEF = (IMG_H_DEF > 1) ? $clog2(IMG_H_DEF) : 1;

  // Byte slot of window element (r, c); r = 0 is the oldest row, c = 0 the leftmost column.
  function automatic int win_idx(input int r, input int c, input int k);
    return r * k + c;
  endfunction

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sliding_window_gen_line_buffer.sv
// One image-row delay line: read the stored pixel at addr, overwrite it with din when en.
module line_buffer
  import cnn_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = IMG_W_DEF
) (
  input  logic                     clock,
  input  logic                     en,
  input  logic [cnt_w(DEPTH)-1:0]  addr,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        dout
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents are deliberately left unreset; readers only trust a column once it was rewritten.
  always_ff @(posedge clock) begin
    if (en) mem[addr] <= din;
  end

  assign dout = mem[addr];

endmodule

// File: rtl/sliding_window_gen.sv
// KxK sliding-window generator: row-major pixel stream in, flattened windows out.
// Optional frame-sync input `sof` when SW_FRAME_SYNC_EN is defined.
module sliding_window_gen
  import cnn_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int K      = 4,
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [DATA_W-1:0]       pixel_in,
`ifdef SW_FRAME_SYNC_EN
  input  logic                    sof,
`endif
  output logic                    out_valid,
  output logic [DATA_W*K*K-1:0]   out_window,
  output logic                    out_last
);

  localparam int COL_W = cnt_w(IMG_W);
  localparam int ROW_W = cnt_w(IMG_H);

  logic [COL_W-1:0]  col, col_eff, col_nxt;
  logic [ROW_W-1:0]  row, row_eff, row_nxt;
  logic              frame_start;
  logic              win_ok, last_px;
  logic [DATA_W-1:0] tap    [K-1];
  logic [DATA_W-1:0] lb_din [K-1];
  logic [DATA_W-1:0] new_col [K];
  logic [DATA_W-1:0] win [K][K];

`ifdef SW_FRAME_SYNC_EN
  assign frame_start = in_valid & sof;
`else
  assign frame_start = 1'b0;
`endif

  // A frame-start pixel is handled exactly as if the counters already sat at (0,0).
  assign col_eff = frame_start ? '0 : col;
  assign row_eff = frame_start ? '0 : row;

  always_comb begin
    col_nxt = col_eff + COL_W'(1);
    row_nxt = row_eff;
    if (col_eff == COL_W'(IMG_W - 1)) begin
      col_nxt = '0;
      row_nxt = (row_eff == ROW_W'(IMG_H - 1)) ? '0 : row_eff + ROW_W'(1);
    end
  end

  assign win_ok  = (row_eff >= ROW_W'(K - 1)) && (col_eff >= COL_W'(K - 1));
  assign last_px = (row_eff == ROW_W'(IMG_H - 1)) && (col_eff == COL_W'(IMG_W - 1));

  // Chain: buffer 0 holds the previous row, buffer j holds the row j+1 above the current one.
  for (genvar j = 0; j < K - 1; j++) begin : g_lb
    if (j == 0) begin : g_head
      assign lb_din[j] = pixel_in;
    end else begin : g_link
      assign lb_din[j] = tap[j-1];
    end

    line_buffer #(
      .DATA_W (DATA_W),
      .DEPTH  (IMG_W)
    ) u_line_buffer (
      .clock (clock),
      .en    (in_valid),
      .addr  (col_eff),
      .din   (lb_din[j]),
      .dout  (tap[j])
    );
  end

  always_comb begin
    for (int r = 0; r < K - 1; r++) new_col[r] = tap[K-2-r];
    new_col[K-1] = pixel_in;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      col       <= '0;
      row       <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++)
          win[r][c] <= '0;
    end else begin
      out_valid <= in_valid & win_ok;
      out_last  <= in_valid & win_ok & last_px;
      if (in_valid) begin
        col <= col_nxt;
        row <= row_nxt;
        for (int r = 0; r < K; r++) begin
          for (int c = 0; c < K - 1; c++) win[r][c] <= win[r][c+1];
          win[r][K-1] <= new_col[r];
        end
      end
    end
  end

  always_comb begin
    out_window = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        out_window[DATA_W*win_idx(r, c, K) +: DATA_W] = win[r][c];
  end

endmodule

// File: tb/tb_sliding_window_gen.sv
// Directed scoreboard bench for sliding_window_gen (8x8 image, K=4).
module tb_sliding_window_gen;

  localparam int DW = 8;
  localparam int K  = 4;
  localparam int W  = 8;
  localparam int H  = 8;
  localparam int OW = DW * K * K;

  logic          clock = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [DW-1:0] pixel_in;
`ifdef SW_FRAME_SYNC_EN
  logic          sof;
`endif
  logic          out_valid;
  logic          out_last;
  logic [OW-1:0] out_window;

  always #5 clock = ~clock;

  sliding_window_gen #(.DATA_W(DW), .K(K), .IMG_W(W), .IMG_H(H)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .pixel_in   (pixel_in),
`ifdef SW_FRAME_SYNC_EN
    .sof        (sof),
`endif
    .out_valid  (out_valid),
    .out_window (out_window),
    .out_last   (out_last)
  );

  typedef struct {
    logic [OW-1:0] win;
    logic          last;
    int            dsum;
  } exp_t;

  exp_t          sbq[$];
  int            compared   = 0;
  int            mismatched = 0;
  int            img [H][W];
  int            m_row = 0;
  int            m_col = 0;
  int            win_cnt = 0;
  logic [OW-1:0] prev_win;
  logic [OW-1:0] fw;

  task automatic check(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int dot2(input logic [OW-1:0] w);
    int s = 0;
    for (int i = 0; i < K * K; i++) s += 2 * int'(w[DW*i +: DW]);
    return s;
  endfunction

  // Drive one cycle; model expected output; compare at the following negedge.
  task automatic step(input logic v, input int p, input logic s);
    exp_t e;
    logic ev = 1'b0;
    logic el = 1'b0;
    in_valid = v;
    pixel_in = DW'(p);
`ifdef SW_FRAME_SYNC_EN
    sof = s;
`endif
    prev_win = out_window;
    if (v) begin
      if (s) begin
        m_row = 0;
        m_col = 0;
      end
      img[m_row][m_col] = p;
      if (m_row >= K - 1 && m_col >= K - 1) begin
        ev = 1'b1;
        el = (m_row == H - 1) && (m_col == W - 1);
        e.win  = '0;
        e.dsum = 0;
        for (int r = 0; r < K; r++)
          for (int c = 0; c < K; c++) begin
            e.win[DW*(r*K+c) +: DW] = DW'(img[m_row-K+1+r][m_col-K+1+c]);
            e.dsum += 2 * img[m_row-K+1+r][m_col-K+1+c];
          end
        e.last = el;
        sbq.push_back(e);
      end
      if (m_col == W - 1) begin
        m_col = 0;
        m_row = (m_row == H - 1) ? 0 : m_row + 1;
      end else begin
        m_col++;
      end
    end
    @(negedge clock);
    check("out_valid", out_valid, ev);
    check("out_last", out_last, el);
    if (!v) check("hold", out_window, prev_win);
    if (out_valid) win_cnt++;
    if (ev) begin
      e = sbq.pop_front();
      check("window", out_window, e.win);
      check("dot_sum", dot2(out_window), e.dsum);
    end
  endtask

  // mode 0: base + index; mode 1: all 3s except row 5 which is all 2s
  task automatic send_range(input int mode, input int base, input int lo, input int hi, input bit gap);
    int p;
    for (int i = lo; i <= hi; i++) begin
      p = (mode == 0) ? base + i : ((i / W == 5) ? 2 : 3);
      step(1'b1, p, 1'b0);
      if (gap) step(1'b0, int'($urandom_range(0, 255)), 1'b0);
    end
  endtask

  initial begin
    reset    = 1'b0;
    in_valid = 1'b0;
    pixel_in = '0;
`ifdef SW_FRAME_SYNC_EN
    sof      = 1'b0;
`endif
    repeat (2) @(negedge clock);
    check("rst_valid", out_valid, 0);
    check("rst_last", out_last, 0);
    check("rst_window", out_window, 0);
    reset = 1'b1;
    @(negedge clock);

    // Frame 1: continuous, with explicit check of the first window
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        fw[DW*(r*K+c) +: DW] = DW'(r * W + c);
    win_cnt = 0;
    send_range(0, 0, 0, 27, 1'b0);
    check("first_window", out_window, fw);
    send_range(0, 0, 28, 63, 1'b0);
    check("f1_count", win_cnt, 25);

    // Frame 2 back-to-back
    win_cnt = 0;
    send_range(0, 0, 0, 27, 1'b0);
    check("f2_first_window", out_window, fw);
    send_range(0, 0, 28, 63, 1'b0);
    check("f2_count", win_cnt, 25);

    // Frame 3 with alternating gaps
    win_cnt = 0;
    send_range(0, 0, 0, 63, 1'b1);
    check("f3_count", win_cnt, 25);

    // Partial frame then a one-cycle reset after pixel 40
    send_range(0, 0, 0, 40, 1'b0);
    in_valid = 1'b0;
    reset    = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_last", out_last, 0);
    check("mid_rst_window", out_window, 0);
    @(negedge clock);
    reset = 1'b1;
    m_row = 0;
    m_col = 0;
    sbq.delete();

    win_cnt = 0;
    send_range(0, 100, 0, 63, 1'b0);
    check("restart_count", win_cnt, 25);

    // All-3s frame with one row of 2s (dot sums 96 / 88)
    win_cnt = 0;
    send_range(1, 0, 0, 63, 1'b0);
    check("int_count", win_cnt, 25);

`ifdef SW_FRAME_SYNC_EN
    win_cnt = 0;
    send_range(0, 0, 0, 19, 1'b0);
    step(1'b1, 0, 1'b1);
    send_range(0, 0, 1, 63, 1'b0);
    check("sof_count", win_cnt, 25);
`endif

    check("sb_drained", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
